// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the LSU memory port: issue/writeback packets, FSM states, access size decode.
// Also holds the funct3 constants and the misalignment test used when LSU_MISALIGN_TRAP_EN is set.
package lsu_mem_port_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 6;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StDrain} lsu_state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             is_store;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  src2;
        logic [TAG_W-1:0] dest_tag;
    } instruction_t;

    typedef struct packed {
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  pc;
        logic             exception;
    } writeback_packet_t;

    // Unknown encodings fall through to a word access.
    function automatic mem_size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SzByte;
            F3_H, F3_HU: return SzHalf;
            default:     return SzWord;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SzHalf:  return off[0];
            SzWord:  return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// req/gnt/rvalid data-memory bus between the LSU memory port (master) and the cache/SRAM (slave).
interface lsu_mem_port_if;
    import lsu_mem_port_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_mem_port_load_align.sv
// Combinational load lane select and sign/zero extension; also reused by store-to-load forwarding.
module lsu_mem_port_load_align
    import lsu_mem_port_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext   = ~funct3_i[2];
        case (decode_size(funct3_i))
            SzByte:  result_o = {{(XLEN-8){byte_v[7] & sext}}, byte_v};
            SzHalf:  result_o = {{(XLEN-16){half_v[15] & sext}}, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU memory port: one load/store in flight over req/gnt/rvalid, result returned to the CDB.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of clearing low bits.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  instruction_t          issue_pkt,
    output logic                  issue_rdy,
    output logic                  cache_stall,
    lsu_mem_port_if.master        mem,
    output logic                  wb_valid,
    output writeback_packet_t     wb_pkt,
    input  logic                  wb_rdy
);

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    writeback_packet_t wb_pkt_q, wb_pkt_d;
    logic              issue_rdy_q, issue_rdy_d, cache_stall_q, cache_stall_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              is_store_q, is_store_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    mem_size_e       in_size;
    logic [1:0]      in_off, eff_off;
    logic [3:0]      in_be;
    logic [XLEN-1:0] in_wdata, load_result;
    logic            trap;

    always_comb begin
        in_size = decode_size(issue_pkt.funct3);
        in_off  = issue_pkt.addr[1:0];
        case (in_size)
            SzByte: begin
                eff_off  = in_off;
                in_be    = 4'b0001 << in_off;
                in_wdata = {4{issue_pkt.src2[7:0]}};
            end
            SzHalf: begin
                eff_off  = {in_off[1], 1'b0};
                in_be    = 4'b0011 << eff_off;
                in_wdata = {2{issue_pkt.src2[15:0]}};
            end
            default: begin
                eff_off  = 2'b00;
                in_be    = 4'b1111;
                in_wdata = issue_pkt.src2;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(in_size, in_off);
`else
    assign trap = 1'b0;
`endif

    lsu_mem_port_load_align u_load_align (
        .rdata_i  (mem.mem_rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .result_o (load_result)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = wb_valid_q;
        wb_pkt_d    = wb_pkt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        is_store_d  = is_store_q;
        tag_d       = tag_q;
        pc_d        = pc_q;

        case (state_q)
            StIdle: begin
                if (issue_valid && !flush) begin
                    funct3_d    = issue_pkt.funct3;
                    off_d       = eff_off;
                    is_store_d  = issue_pkt.is_store;
                    tag_d       = issue_pkt.dest_tag;
                    pc_d        = issue_pkt.pc;
                    mem_we_d    = issue_pkt.is_store;
                    mem_addr_d  = {issue_pkt.addr[ADDR_W-1:2], eff_off};
                    mem_be_d    = issue_pkt.is_store ? in_be : 4'b1111;
                    mem_wdata_d = issue_pkt.is_store ? in_wdata : '0;
                    if (trap) begin
                        state_d            = StResp;
                        wb_valid_d         = 1'b1;
                        wb_pkt_d.dest_tag  = issue_pkt.dest_tag;
                        wb_pkt_d.result    = issue_pkt.addr;
                        wb_pkt_d.pc        = issue_pkt.pc;
                        wb_pkt_d.exception = 1'b1;
                    end else begin
                        state_d   = StReq;
                        mem_req_d = 1'b1;
                    end
                end
            end
            StReq: begin
                // A grant coinciding with flush still owes us an rvalid, so drain it.
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = flush ? StDrain : StWait;
                end else if (flush) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d            = StResp;
                        wb_valid_d         = 1'b1;
                        wb_pkt_d.dest_tag  = tag_q;
                        wb_pkt_d.result    = is_store_q ? '0 : load_result;
                        wb_pkt_d.pc        = pc_q;
                        wb_pkt_d.exception = 1'b0;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem.mem_rvalid) state_d = StIdle;
            end
            StResp: begin
                if (flush || wb_rdy) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        issue_rdy_d   = (state_d == StIdle);
        cache_stall_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_pkt_q      <= '0;
            issue_rdy_q   <= 1'b1;
            cache_stall_q <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            is_store_q    <= 1'b0;
            tag_q         <= '0;
            pc_q          <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_pkt_q      <= wb_pkt_d;
            issue_rdy_q   <= issue_rdy_d;
            cache_stall_q <= cache_stall_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            is_store_q    <= is_store_d;
            tag_q         <= tag_d;
            pc_q          <= pc_d;
        end
    end

    assign issue_rdy     = issue_rdy_q;
    assign cache_stall   = cache_stall_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_pkt        = wb_pkt_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: inputs change and outputs are sampled on the falling edge.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    logic              issue_valid = 1'b0;
    logic              wb_rdy = 1'b1;
    instruction_t      issue_pkt;
    logic              issue_rdy, cache_stall, wb_valid;
    writeback_packet_t wb_pkt;
    int                total = 0;
    int                bad = 0;

    lsu_mem_port_if mem_if ();

    lsu_mem_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_pkt   (issue_pkt),
        .issue_rdy   (issue_rdy),
        .cache_stall (cache_stall),
        .mem         (mem_if),
        .wb_valid    (wb_valid),
        .wb_pkt      (wb_pkt),
        .wb_rdy      (wb_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] src2, input logic [5:0] tag_id);
        issue_pkt          = '0;
        issue_pkt.pc       = 32'h8000_0000 | {26'd0, tag_id};
        issue_pkt.is_store = st;
        issue_pkt.funct3   = f3;
        issue_pkt.addr     = addr;
        issue_pkt.src2     = src2;
        issue_pkt.dest_tag = tag_id;
        issue_valid        = 1'b1;
        cyc();
        issue_valid        = 1'b0;
    endtask

    // Full transaction: grant after gnt_dly stalled cycles, rvalid next cycle, CDB takes after rdy_dly.
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] src2, input logic [31:0] rdata,
                       input int gnt_dly, input int rdy_dly, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] eaddr, input logic [31:0] eres,
                       input logic [5:0] tag_id);
        issue(st, f3, addr, src2, tag_id);
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, "_req"}, mem_if.mem_req, 1);
            chk({tag, "_we"}, mem_if.mem_we, st);
            chk({tag, "_addr"}, mem_if.mem_addr, eaddr);
            chk({tag, "_be"}, mem_if.mem_be, ebe);
            chk({tag, "_wdata"}, mem_if.mem_wdata, ewd);
            chk({tag, "_rdy_req"}, issue_rdy, 0);
            if (i == gnt_dly) mem_if.mem_gnt = 1'b1;
            cyc();
        end
        mem_if.mem_gnt = 1'b0;
        chk({tag, "_req_drop"}, mem_if.mem_req, 0);
        chk({tag, "_stall_wait"}, cache_stall, 1);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = rdata;
        wb_rdy            = (rdy_dly == 0);
        cyc();
        mem_if.mem_rvalid = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk({tag, "_wbv"}, wb_valid, 1);
            chk({tag, "_result"}, wb_pkt.result, eres);
            chk({tag, "_tag"}, wb_pkt.dest_tag, tag_id);
            chk({tag, "_pc"}, wb_pkt.pc, 32'h8000_0000 | {26'd0, tag_id});
            chk({tag, "_exc"}, wb_pkt.exception, 0);
            chk({tag, "_rdy_resp"}, issue_rdy, 0);
            if (i == rdy_dly) wb_rdy = 1'b1;
            cyc();
        end
        chk({tag, "_wbv_done"}, wb_valid, 0);
        chk({tag, "_rdy_idle"}, issue_rdy, 1);
    endtask

    initial begin
        issue_pkt         = '0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_issue_rdy", issue_rdy, 1);
        chk("rst_stall", cache_stall, 0);
        chk("rst_req", mem_if.mem_req, 0);
        chk("rst_we", mem_if.mem_we, 0);
        chk("rst_addr", mem_if.mem_addr, 0);
        chk("rst_be", mem_if.mem_be, 0);
        chk("rst_wdata", mem_if.mem_wdata, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wb_result", wb_pkt.result, 0);
        chk("rst_wb_tag", wb_pkt.dest_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        run("lw", 0, F3_W, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 4'hF, 0, 32'h100, 32'hDEAD_BEEF, 1);
        run("lb", 0, F3_B, 32'h103, 0, 32'h8012_3456, 0, 0, 4'hF, 0, 32'h103, 32'hFFFF_FF80, 2);
        run("lbu", 0, F3_BU, 32'h103, 0, 32'h8012_3456, 0, 0, 4'hF, 0, 32'h103, 32'h0000_0080, 3);
        run("lhu", 0, F3_HU, 32'h102, 0, 32'hBEEF_0000, 0, 3, 4'hF, 0, 32'h102, 32'h0000_BEEF, 4);
        run("lh", 0, F3_H, 32'h100, 0, 32'h1234_F00D, 0, 0, 4'hF, 0, 32'h100, 32'hFFFF_F00D, 5);
        run("lb0", 0, F3_B, 32'h100, 0, 32'hAAAA_AA7F, 0, 0, 4'hF, 0, 32'h100, 32'h0000_007F, 6);
        run("sb", 1, F3_B, 32'h201, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 4'b0010,
            32'h7878_7878, 32'h201, 0, 7);
        run("sh", 1, F3_H, 32'h202, 32'hAAAA_5555, 32'hFFFF_FFFF, 5, 0, 4'b1100,
            32'h5555_5555, 32'h202, 0, 8);
        run("sw", 1, F3_W, 32'h204, 32'hCAFE_F00D, 32'h0, 0, 0, 4'hF,
            32'hCAFE_F00D, 32'h204, 0, 9);
        run("f3_undef", 0, 3'b011, 32'h108, 0, 32'h0102_0304, 0, 0, 4'hF, 0, 32'h108,
            32'h0102_0304, 10);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, F3_W, 32'h102, 0, 11);
        chk("mis_req", mem_if.mem_req, 0);
        chk("mis_wbv", wb_valid, 1);
        chk("mis_exc", wb_pkt.exception, 1);
        chk("mis_result", wb_pkt.result, 32'h102);
        chk("mis_tag", wb_pkt.dest_tag, 11);
        cyc();
        chk("mis_idle", issue_rdy, 1);
        chk("mis_req2", mem_if.mem_req, 0);
`else
        run("lw_mis", 0, F3_W, 32'h102, 0, 32'h1122_3344, 0, 0, 4'hF, 0, 32'h100,
            32'h1122_3344, 11);
        run("sh_mis", 1, F3_H, 32'h203, 32'h0000_BEEF, 0, 0, 0, 4'b1100,
            32'hBEEF_BEEF, 32'h202, 0, 12);
`endif

        // Flush while requesting: no grant, back to idle.
        issue(0, F3_W, 32'h300, 0, 13);
        chk("freq_req", mem_if.mem_req, 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("freq_req_off", mem_if.mem_req, 0);
        chk("freq_rdy", issue_rdy, 1);
        chk("freq_stall", cache_stall, 0);
        cyc();
        chk("freq_wbv", wb_valid, 0);

        // Flush while waiting: late rvalid is swallowed.
        issue(0, F3_W, 32'h304, 0, 14);
        mem_if.mem_gnt = 1'b1;
        cyc();
        mem_if.mem_gnt = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fwait_stall", cache_stall, 1);
        chk("fwait_rdy", issue_rdy, 0);
        chk("fwait_wbv", wb_valid, 0);
        cyc();
        cyc();
        chk("fwait_drain", issue_rdy, 0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h5A5A_5A5A;
        cyc();
        mem_if.mem_rvalid = 1'b0;
        chk("fwait_idle", issue_rdy, 1);
        chk("fwait_wbv2", wb_valid, 0);
        cyc();
        chk("fwait_wbv3", wb_valid, 0);

        // Flush in the same cycle as issue: op not taken.
        issue_pkt.addr = 32'h400;
        issue_valid    = 1'b1;
        flush          = 1'b1;
        cyc();
        issue_valid = 1'b0;
        flush       = 1'b0;
        chk("fiss_req", mem_if.mem_req, 0);
        chk("fiss_stall", cache_stall, 0);

        // Stray rvalid in idle.
        mem_if.mem_rvalid = 1'b1;
        cyc();
        mem_if.mem_rvalid = 1'b0;
        chk("stray_wbv", wb_valid, 0);
        chk("stray_rdy", issue_rdy, 1);

        // Flush while holding a response: packet dropped.
        issue(0, F3_W, 32'h500, 0, 15);
        mem_if.mem_gnt = 1'b1;
        cyc();
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h0BAD_0BAD;
        wb_rdy            = 1'b0;
        cyc();
        mem_if.mem_rvalid = 1'b0;
        chk("fresp_wbv", wb_valid, 1);
        flush = 1'b1;
        cyc();
        flush  = 1'b0;
        wb_rdy = 1'b1;
        chk("fresp_drop", wb_valid, 0);
        chk("fresp_rdy", issue_rdy, 1);

        // Asynchronous reset mid-request.
        issue(0, F3_W, 32'h600, 0, 16);
        chk("arst_req_pre", mem_if.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", mem_if.mem_req, 0);
        chk("arst_stall", cache_stall, 0);
        chk("arst_rdy", issue_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        run("lw_after", 0, F3_W, 32'h700, 0, 32'h7654_3210, 0, 0, 4'hF, 0, 32'h700,
            32'h7654_3210, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
